amplifier_mc: RTL and testbench
===============================

Name: amplifier_mc

Overview:
Multi-channel, parametrised successor to the single-channel amplifier.
- Holds one scaler register per channel.
- Multiplies each incoming tagged base number by its channel's scaler.
- Optionally saturates the product to the result width.
- Buffers results in an output FIFO with ready/valid backpressure, so a slow consumer no longer loses results.

Parameters:
CH_NUM, 4, number of channels (>=1)
ID_WIDTH, 8, width of the tag ("no") field carried with each sample
BASE_WIDTH, 8, width of the base-number field
SCALER_WIDTH, 16, scaler width; must be <= ID_WIDTH+BASE_WIDTH
RES_WIDTH, 24, result width; may be < BASE_WIDTH+SCALER_WIDTH
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
SAT_EN, 1, 1 = saturate overflowing results, 0 = truncate to low RES_WIDTH bits

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; one clock, reset asynchronous active-low
wr_en_i  in  1  write strobe
set_scaler_i  in  1  1 = scaler write, 0 = data write
wr_ch_i  in  CW=max(1,$clog2(CH_NUM))  target channel
wr_data_i  in  ID_WIDTH+BASE_WIDTH  data write: {id, base}; scaler write: low SCALER_WIDTH bits
wr_ready_o  out  1  data write accepted this cycle when high
rd_val_o  out  1  FIFO head valid
rd_ready_i  in  1  consumer accepts head
rd_data_o  out  ID_WIDTH+RES_WIDTH  {id, result}
rd_ch_o  out  CW  channel of head entry
rd_ovf_o  out  1  head entry overflowed (saturated or truncated)
scaler_o  out  SCALER_WIDTH  last scaler value written (any channel)
err_o  out  1  one-cycle pulse: write dropped (bad channel)

Behaviour:
- Reset (async assert, sync release):
  - All scalers, scaler_o, FIFO pointers and count go to 0.
  - rd_val_o=0, wr_ready_o=1, err_o=0; rd_data_o/rd_ch_o/rd_ovf_o = 0.
  - Reset mid-operation discards all queued entries.
- Scaler write (wr_en_i & set_scaler_i, wr_ch_i<CH_NUM):
  - scaler[wr_ch_i] and scaler_o update at the same edge.
  - Always accepted, independent of wr_ready_o; never enters the FIFO.
- Data write (wr_en_i & !set_scaler_i & wr_ready_o, wr_ch_i<CH_NUM):
  - At the edge, pushes {ch, id, res, ovf}.
  - prod = base * scaler[ch], full width BASE_WIDTH+SCALER_WIDTH, unsigned; the scaler value is the one registered before this edge.
  - A scaler write on cycle k followed by a data write on k+1 uses the new scaler.
  - ovf = |prod[top bits above RES_WIDTH]|.
  - res = ovf ? (SAT_EN ? all-ones : prod[RES_WIDTH-1:0]) : prod.
- Data write with wr_ready_o=0: ignored, no error, upstream must hold.
- wr_ch_i >= CH_NUM (either write type): write dropped, err_o pulses high for 1 cycle after the edge.
- Latency: data accepted at edge k into an empty FIFO gives rd_val_o=1 and valid rd_data_o after edge k (1 cycle).
- Output handshake:
  - rd_val_o = (count != 0); head outputs come straight from FIFO storage.
  - Pop on rd_val_o & rd_ready_i.
  - Head must remain stable while rd_val_o & !rd_ready_i.
- wr_ready_o = (count != FIFO_DEPTH), registered from count; no same-cycle bypass when full.
- Simultaneous push and pop: count unchanged, order preserved (strict FIFO). Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- amplifier_pkg holds:
  - default width localparams (ID/BASE/SCALER/RES);
  - typedef of the FIFO entry struct {ch, id, res, ovf};
  - a saturate/truncate function parametrised by SAT_EN.
- Sub-module amplifier_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count/head. Same clock and reset style.
- Multiplier, scaler bank and error logic live in amplifier_mc.

Test Plan:
- Basic: ch0 scaler write 100, then data write {5,25} on ch0 -> after 1 edge rd_val_o=1, rd_data_o={5,2500}, rd_ch_o=0, rd_ovf_o=0, scaler_o=100.
- Channel isolation: scalers ch1=3, ch2=7; writes {1,10} ch1 and {2,10} ch2 -> results in order {1,30}, {2,70}.
- Backpressure: rd_ready_i=0, 5 data writes with ids 1..5.
  - wr_ready_o drops after the 4th write; the 5th is not accepted.
  - Head stays at id 1.
  - Then rd_ready_i=1: ids 1..4 drain in order, and wr_ready_o returns high after the first pop.
- Overflow: instance with RES_WIDTH=20.
  - Scaler 65535, base 255, SAT_EN=1 -> res=0xFFFFF, rd_ovf_o=1.
  - Same with SAT_EN=0 -> res=0xEFF01, rd_ovf_o=1.
- Bad channel: data write with wr_ch_i=5 (CH_NUM=4) -> err_o pulses 1 cycle, FIFO count unchanged.
- Reset mid-operation: 3 entries queued, assert rstn_i low asynchronously mid-cycle -> rd_val_o=0 immediately. After release, a data write on ch0 yields res=0 (scaler reset to 0).

Source files
------------

// File: rtl/amplifier_pkg.sv
// Shared widths, entry layout and result-fitting helper for the multi-channel amplifier.
package amplifier_pkg;

  localparam int unsigned ChNumDef       = 4;
  localparam int unsigned IdWidthDef     = 8;
  localparam int unsigned BaseWidthDef   = 8;
  localparam int unsigned ScalerWidthDef = 16;
  localparam int unsigned ResWidthDef    = 24;
  localparam int unsigned FifoDepthDef   = 4;

  // Widest product the fitting helper handles.
  localparam int unsigned ProdMaxWidth = 64;

  // Entry layout for the default configuration.
  typedef struct packed {
    logic [1:0]                ch;
    logic [IdWidthDef-1:0]     id;
    logic [ResWidthDef-1:0]    res;
    logic                      ovf;
  } amp_entry_t;

  // Returns {ovf, res}: res is the product fitted into res_w bits, either clamped to all-ones
  // (sat_en) or truncated to its low bits. res_w must be below ProdMaxWidth.
  function automatic logic [ProdMaxWidth:0] fit_result(input logic [ProdMaxWidth-1:0] prod,
                                                       input int unsigned res_w,
                                                       input bit sat_en);
    logic [ProdMaxWidth-1:0] mask;
    logic [ProdMaxWidth-1:0] res;
    logic                    ovf;
    mask = (ProdMaxWidth'(1) << res_w) - ProdMaxWidth'(1);
    ovf  = |(prod & ~mask);
    if (ovf && sat_en) begin
      res = mask;
    end else begin
      res = prod & mask;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/amplifier_fifo.sv
// Synchronous FIFO with registered count; head is read straight from storage.
module amplifier_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/amplifier_mc.sv
// Multi-channel amplifier: per-channel scaler bank, multiply/fit, and a ready/valid output FIFO.
module amplifier_mc
  import amplifier_pkg::*;
#(
  parameter int unsigned CH_NUM       = ChNumDef,
  parameter int unsigned ID_WIDTH     = IdWidthDef,
  parameter int unsigned BASE_WIDTH   = BaseWidthDef,
  parameter int unsigned SCALER_WIDTH = ScalerWidthDef,
  parameter int unsigned RES_WIDTH    = ResWidthDef,
  parameter int unsigned FIFO_DEPTH   = FifoDepthDef,
  parameter int unsigned SAT_EN       = 1,
  localparam int unsigned CW          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          wr_en_i,
  input  logic                          set_scaler_i,
  input  logic [CW-1:0]                 wr_ch_i,
  input  logic [ID_WIDTH+BASE_WIDTH-1:0] wr_data_i,
  output logic                          wr_ready_o,
  output logic                          rd_val_o,
  input  logic                          rd_ready_i,
  output logic [ID_WIDTH+RES_WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]                 rd_ch_o,
  output logic                          rd_ovf_o,
  output logic [SCALER_WIDTH-1:0]       scaler_o,
  output logic                          err_o
);

  localparam int unsigned DW = ID_WIDTH + BASE_WIDTH;
  localparam int unsigned PW = BASE_WIDTH + SCALER_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [CW-1:0]        ch;
    logic [ID_WIDTH-1:0]  id;
    logic [RES_WIDTH-1:0] res;
    logic                 ovf;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  logic [SCALER_WIDTH-1:0] scaler_q [CH_NUM];
  logic [SCALER_WIDTH-1:0] scaler_out_q;
  logic                    err_q, err_d;

  logic                    ch_ok;
  logic                    scaler_we;
  logic                    data_push;
  logic [SCALER_WIDTH-1:0] sel_scaler;
  logic [BASE_WIDTH-1:0]   base;
  logic [ID_WIDTH-1:0]     id;
  logic [PW-1:0]           prod;
  logic [ProdMaxWidth:0]   fit;
  logic                    unused_fit;
  entry_t                  push_entry;
  entry_t                  head_entry;
  logic [EW-1:0]           head_bits;
  logic                    fifo_full, fifo_empty;
  logic [AW:0]             unused_fifo_count;

  assign ch_ok = (32'(wr_ch_i) < CH_NUM);
  assign base  = wr_data_i[BASE_WIDTH-1:0];
  assign id    = wr_data_i[DW-1:BASE_WIDTH];

  assign scaler_we = wr_en_i & set_scaler_i & ch_ok;
  // Accept only when there is room; upstream holds the write otherwise.
  assign data_push = wr_en_i & ~set_scaler_i & ch_ok & ~fifo_full;
  assign err_d     = wr_en_i & ~ch_ok;

  // Multiplies with the registered scaler, so a same-edge scaler write is not seen.
  assign sel_scaler = ch_ok ? scaler_q[wr_ch_i] : '0;
  assign prod       = PW'(base) * PW'(sel_scaler);
  assign fit        = fit_result(ProdMaxWidth'(prod), RES_WIDTH, SAT_EN != 0);
  assign unused_fit = ^fit[ProdMaxWidth-1:RES_WIDTH];

  always_comb begin
    push_entry     = '0;
    push_entry.ch  = wr_ch_i;
    push_entry.id  = id;
    push_entry.res = fit[RES_WIDTH-1:0];
    push_entry.ovf = fit[ProdMaxWidth];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(CH_NUM); i++) begin
        scaler_q[i] <= '0;
      end
      scaler_out_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= err_d;
      if (scaler_we) begin
        scaler_q[wr_ch_i] <= wr_data_i[SCALER_WIDTH-1:0];
        scaler_out_q      <= wr_data_i[SCALER_WIDTH-1:0];
      end
    end
  end

  amplifier_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (data_push),
    .data_i  (push_entry),
    .pop_i   (rd_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count),
    .head_o  (head_bits)
  );

  assign head_entry = entry_t'(head_bits);

  assign wr_ready_o = ~fifo_full;
  assign rd_val_o   = ~fifo_empty;
  assign rd_data_o  = {head_entry.id, head_entry.res};
  assign rd_ch_o    = head_entry.ch;
  assign rd_ovf_o   = head_entry.ovf;
  assign scaler_o   = scaler_out_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_amplifier_mc.sv
// Scoreboard bench for amplifier_mc: default instance, two 20-bit-result overflow instances,
// and a 5-channel instance for the bad-channel case.
module tb_amplifier_mc;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  ch;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        set_scaler = 1'b0;
  logic [2:0]  wr_ch = '0;
  logic [15:0] wr_data = '0;
  logic        en_m = 1'b0, en_o = 1'b0, en_b = 1'b0;
  logic        rd_ready = 1'b1;

  logic        wr_ready_m, rd_val_m, rd_ovf_m, err_m;
  logic [31:0] rd_data_m;
  logic [1:0]  rd_ch_m;
  logic [15:0] scaler_m;

  logic        wr_ready_s, rd_val_s, rd_ovf_s, err_s;
  logic [27:0] rd_data_s;
  logic [1:0]  rd_ch_s;
  logic [15:0] scaler_s;

  logic        wr_ready_t, rd_val_t, rd_ovf_t, err_t;
  logic [27:0] rd_data_t;
  logic [1:0]  rd_ch_t;
  logic [15:0] scaler_t;

  logic        wr_ready_b, rd_val_b, rd_ovf_b, err_b;
  logic [31:0] rd_data_b;
  logic [2:0]  rd_ch_b;
  logic [15:0] scaler_b;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t q_t[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  amplifier_mc dut (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(en_m), .set_scaler_i(set_scaler),
    .wr_ch_i(wr_ch[1:0]), .wr_data_i(wr_data), .wr_ready_o(wr_ready_m), .rd_val_o(rd_val_m),
    .rd_ready_i(rd_ready), .rd_data_o(rd_data_m), .rd_ch_o(rd_ch_m), .rd_ovf_o(rd_ovf_m),
    .scaler_o(scaler_m), .err_o(err_m)
  );

  amplifier_mc #(.RES_WIDTH(20), .SAT_EN(1)) dut_sat (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(en_o), .set_scaler_i(set_scaler),
    .wr_ch_i(wr_ch[1:0]), .wr_data_i(wr_data), .wr_ready_o(wr_ready_s), .rd_val_o(rd_val_s),
    .rd_ready_i(1'b1), .rd_data_o(rd_data_s), .rd_ch_o(rd_ch_s), .rd_ovf_o(rd_ovf_s),
    .scaler_o(scaler_s), .err_o(err_s)
  );

  amplifier_mc #(.RES_WIDTH(20), .SAT_EN(0)) dut_trunc (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(en_o), .set_scaler_i(set_scaler),
    .wr_ch_i(wr_ch[1:0]), .wr_data_i(wr_data), .wr_ready_o(wr_ready_t), .rd_val_o(rd_val_t),
    .rd_ready_i(1'b1), .rd_data_o(rd_data_t), .rd_ch_o(rd_ch_t), .rd_ovf_o(rd_ovf_t),
    .scaler_o(scaler_t), .err_o(err_t)
  );

  amplifier_mc #(.CH_NUM(5)) dut_bad (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(en_b), .set_scaler_i(set_scaler),
    .wr_ch_i(wr_ch), .wr_data_i(wr_data), .wr_ready_o(wr_ready_b), .rd_val_o(rd_val_b),
    .rd_ready_i(1'b1), .rd_data_o(rd_data_b), .rd_ch_o(rd_ch_b), .rd_ovf_o(rd_ovf_b),
    .scaler_o(scaler_b), .err_o(err_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input logic [31:0] data, input logic [2:0] ch,
                         input logic ovf, inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got data 0x%0h, expected no entry", name, data);
    end else begin
      e = q.pop_front();
      chk({name, "_data"}, 64'(data), 64'(e.data));
      chk({name, "_ch"}, 64'(ch), 64'(e.ch));
      chk({name, "_ovf"}, 64'(ovf), 64'(e.ovf));
    end
  endtask

  // Monitors: compare on every handshake, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_val_m && rd_ready) pop_chk("main", rd_data_m, 3'(rd_ch_m), rd_ovf_m, q_m);
      if (rd_val_s) pop_chk("sat", 32'(rd_data_s), 3'(rd_ch_s), rd_ovf_s, q_s);
      if (rd_val_t) pop_chk("trunc", 32'(rd_data_t), 3'(rd_ch_t), rd_ovf_t, q_t);
    end
  end

  // Called just after a posedge; holds the write for one edge. tgt: 0 main, 1 overflow, 2 bad.
  task automatic wr(input logic sc, input logic [2:0] ch, input logic [15:0] d, input int tgt);
    set_scaler = sc;
    wr_ch      = ch;
    wr_data    = d;
    en_m       = (tgt == 0);
    en_o       = (tgt == 1);
    en_b       = (tgt == 2);
    @(posedge clk);
    #1;
    en_m = 1'b0;
    en_o = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic expect_m(input logic [7:0] id, input logic [23:0] res, input logic [2:0] ch);
    exp_t e;
    e.data = {id, res};
    e.ch   = ch;
    e.ovf  = 1'b0;
    q_m.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (q_m.size() + q_s.size() + q_t.size()) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk(name, 64'(q_m.size() + q_s.size() + q_t.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_val", 64'(rd_val_m), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready_m), 64'd1);
    chk("rst_err", 64'(err_m), 64'd0);
    chk("rst_rd_data", 64'(rd_data_m), 64'd0);
    chk("rst_rd_ch", 64'(rd_ch_m), 64'd0);
    chk("rst_rd_ovf", 64'(rd_ovf_m), 64'd0);
    chk("rst_scaler", 64'(scaler_m), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 25 * 100 = 2500 tagged 5.
    wr(1'b1, 3'd0, 16'd100, 0);
    chk("basic_scaler_o", 64'(scaler_m), 64'd100);
    expect_m(8'd5, 24'd2500, 3'd0);
    wr(1'b0, 3'd0, {8'd5, 8'd25}, 0);
    chk("basic_latency_val", 64'(rd_val_m), 64'd1);
    drain("basic_drain");

    // Channel isolation: ch1 x3, ch2 x7.
    wr(1'b1, 3'd1, 16'd3, 0);
    wr(1'b1, 3'd2, 16'd7, 0);
    chk("iso_scaler_o", 64'(scaler_m), 64'd7);
    expect_m(8'd1, 24'd30, 3'd1);
    wr(1'b0, 3'd1, {8'd1, 8'd10}, 0);
    expect_m(8'd2, 24'd70, 3'd2);
    wr(1'b0, 3'd2, {8'd2, 8'd10}, 0);
    drain("iso_drain");

    // Backpressure: four fit, the fifth is refused while full.
    rd_ready = 1'b0;
    for (int id = 1; id <= 4; id++) begin
      expect_m(8'(id), 24'(id * 100), 3'd0);
      wr(1'b0, 3'd0, {8'(id), 8'(id)}, 0);
    end
    chk("bp_full_ready", 64'(wr_ready_m), 64'd0);
    wr(1'b0, 3'd0, {8'd5, 8'd5}, 0);
    chk("bp_head_id1", 64'(rd_data_m), 64'({8'd1, 24'd100}));
    repeat (3) @(posedge clk);
    #1;
    chk("bp_head_stable", 64'(rd_data_m), 64'({8'd1, 24'd100}));
    chk("bp_val_held", 64'(rd_val_m), 64'd1);
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_after_pop", 64'(wr_ready_m), 64'd1);
    drain("bp_drain");
    chk("bp_empty_after", 64'(rd_val_m), 64'd0);

    // Overflow on 20-bit results: 255 * 65535 = 0xFEFF01.
    wr(1'b1, 3'd0, 16'hFFFF, 1);
    e.data = {4'd0, 8'd7, 20'hFFFFF};
    e.ch   = 3'd0;
    e.ovf  = 1'b1;
    q_s.push_back(e);
    e.data = {4'd0, 8'd7, 20'hEFF01};
    q_t.push_back(e);
    wr(1'b0, 3'd0, {8'd7, 8'd255}, 1);
    drain("ovf_drain");

    // Bad channel on a 5-channel instance.
    wr(1'b0, 3'd5, {8'd3, 8'd3}, 2);
    chk("bad_err_pulse", 64'(err_b), 64'd1);
    chk("bad_no_push", 64'(rd_val_b), 64'd0);
    @(posedge clk);
    #1;
    chk("bad_err_clear", 64'(err_b), 64'd0);
    chk("bad_still_empty", 64'(rd_val_b), 64'd0);
    wr(1'b1, 3'd5, 16'h1234, 2);
    chk("bad_sc_err", 64'(err_b), 64'd1);
    chk("bad_sc_unchanged", 64'(scaler_b), 64'd0);

    // Reset mid-operation with entries queued.
    rd_ready = 1'b0;
    for (int id = 1; id <= 3; id++) begin
      wr(1'b0, 3'd0, {8'(id), 8'd1}, 0);
    end
    chk("mid_queued_val", 64'(rd_val_m), 64'd1);
    #2;
    rstn = 1'b0;
    q_m.delete();
    #1;
    chk("mid_rst_val", 64'(rd_val_m), 64'd0);
    chk("mid_rst_ready", 64'(wr_ready_m), 64'd1);
    chk("mid_rst_scaler", 64'(scaler_m), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_m(8'd9, 24'd0, 3'd0);
    wr(1'b0, 3'd0, {8'd9, 8'd50}, 0);
    drain("mid_post_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
